sram_lsu_bridge: RTL and testbench
==================================

# sram_lsu_bridge

Load/store adapter sitting directly upstream of the internal SRAM: accepts byte/halfword/word load and store requests from the core over a valid/ready handshake and converts them into word-wide SRAM accesses. Sub-word stores become read-modify-write sequences, because the SRAM has no byte enables. The bridge drives one SRAM read port plus the SRAM write port, and returns aligned, extended load data over a valid/ready response channel.

## Interface
- num_words, 4096: SRAM depth in words; must match the attached SRAM.
- l2_num_words, 12: log2(num_words); SRAM word-address width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  bridge can accept a request (high only in IDLE).
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  l2_num_words+2  byte address.
- i_req_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- i_req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- i_req_wdata  in  `WORD_SIZE (32)  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_resp_valid  out  1  response present.
- i_resp_ready  in  1  consumer takes response.
- o_resp_rdata  out  `WORD_SIZE  extended load data; 0 for stores.
- o_resp_error  out  1  misaligned access (see Configuration).
- o_sram_read_enable  out  1  to SRAM read enable.
- o_sram_addr_read  out  l2_num_words  to SRAM read address.
- i_sram_data_read  in  `WORD_SIZE  from SRAM read data (registered by SRAM, valid the cycle after read enable).
- o_sram_write_enable  out  1  to SRAM write enable.
- o_sram_addr_write  out  l2_num_words  to SRAM write address.
- o_sram_data_to_write  out  `WORD_SIZE  to SRAM write data.

## Operation
- States: IDLE, RD, DATA, WR, RESP. Reset → IDLE. All registers clear, so every output is 0 except o_req_ready = 1.
- IDLE: o_req_ready = 1. On i_req_valid, latch addr, size, we, unsigned, and wdata. Misaligned means a half with addr[0] = 1, or a word with addr[1:0] ≠ 0. Misaligned (trap enabled) → RESP with error. Word store → WR. Any other request → RD.
- RD: o_sram_read_enable = 1, o_sram_addr_read = addr[l2+1:2]; → DATA.
- DATA, load: o_resp_rdata is loaded with the extracted lane, extended per size/unsigned; → RESP.
- DATA, store: merged word register is loaded with i_sram_data_read, with the target lane(s) replaced by wdata; → WR.
- Lanes are little-endian. Byte k occupies [8k+7:8k], k = addr[1:0]. A halfword occupies bytes addr[1] × 2 and addr[1] × 2 + 1.
- WR: o_sram_write_enable = 1, o_sram_addr_write = word address, o_sram_data_to_write = wdata (word store) or the merged word; → RESP.
- RESP: o_resp_valid = 1, and o_resp_rdata / o_resp_error are held stable. When i_resp_ready = 1 → IDLE.
- SRAM enables are decoded from state only: each is exactly one cycle wide, the two are never high together, and both are 0 outside RD/WR.
- Only one request is in flight, so there is no forwarding hazard.

## Timing
- Accept edge = T0.
- Load: RD in T1, DATA in T2, o_resp_valid from T3.
- Word store: WR in T1, o_resp_valid from T2.
- Sub-word store: RD in T1, DATA in T2, WR in T3, o_resp_valid from T4.
- Misaligned (trap): o_resp_valid from T1; no SRAM enable ever asserted.
- Back-to-back: o_req_ready rises in the cycle after the response handshake. Minimum load throughput is one request per 4 cycles.
- i_resp_ready held low stalls in RESP indefinitely with outputs stable.
- Asynchronous reset in any state forces IDLE immediately. An in-progress WR is dropped: the write enable falls asynchronously, and no partial write occurs on the next edge.

## Configuration
- SRAM_BRIDGE_MISALIGN_TRAP_EN defined: misaligned requests get o_resp_error = 1, o_resp_rdata = 0, and no SRAM access.
- SRAM_BRIDGE_MISALIGN_TRAP_EN undefined: o_resp_error is tied 0. Misaligned address low bits are forced to 0 (half: addr[0]; word: addr[1:0]), and the access proceeds normally.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x010, then word load 0x010 → SRAM write at word 4; load response 0xDEADBEEF at T3, error 0.
- Store byte 0x5A to addr 0x012 over word 0xDEADBEEF → SRAM read then write of 0xDE5ABEEF; response at T4.
- Signed byte load addr 0x013 of 0x80112233 → 0xFFFFFF80. Unsigned halfword load addr 0x012 of the same word → 0x00008011.
- Halfword load addr 0x011: with the macro, error = 1 at T1 and no SRAM enable; without it, the access reads addr 0x010 and error = 0.
- Hold i_resp_ready low for 5 cycles after a load → o_resp_valid and data stable, o_req_ready 0. Release → IDLE next cycle, ready 1.
- Assert i_rst_n low during WR of a byte store → write enable drops immediately; SRAM word unchanged; after release, IDLE with o_req_ready 1 and all other outputs 0.

Source files
------------

// File: rtl/sram_lsu_bridge.sv
// sram_lsu_bridge: core load/store requests -> word-wide SRAM accesses.
// Sub-word stores become read-modify-write because the SRAM has no byte
// enables. One request in flight at a time.
// Optional feature macro: SRAM_BRIDGE_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests return error, no SRAM access
//   undefined : misaligned low address bits are forced to 0, error tied 0
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module sram_lsu_bridge #(
  parameter int num_words    = 4096,
  parameter int l2_num_words = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [l2_num_words+1:0]   i_req_addr,
  input  logic [1:0]                i_req_size,
  input  logic                      i_req_unsigned,
  input  logic [`WORD_SIZE-1:0]     i_req_wdata,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [`WORD_SIZE-1:0]     o_resp_rdata,
  output logic                      o_resp_error,
  output logic                      o_sram_read_enable,
  output logic [l2_num_words-1:0]   o_sram_addr_read,
  input  logic [`WORD_SIZE-1:0]     i_sram_data_read,
  output logic                      o_sram_write_enable,
  output logic [l2_num_words-1:0]   o_sram_addr_write,
  output logic [`WORD_SIZE-1:0]     o_sram_data_to_write
);

  // Depth and address width must describe the same SRAM.
  if (num_words != (1 << l2_num_words)) begin : g_bad_cfg
    $error("sram_lsu_bridge: num_words must equal 2**l2_num_words");
  end

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

  state_t                    state, state_nxt;
  logic [l2_num_words+1:0]   addr_q, addr_in;
  logic [1:0]                size_q;
  logic                      we_q, uns_q;
  logic [`WORD_SIZE-1:0]     wdata_q;   // store data, later the merged RMW word
  logic [`WORD_SIZE-1:0]     rdata_q;
  logic                      misaligned, mis_trap;
  logic [`WORD_SIZE-1:0]     merged, loaded, shifted;
  logic [l2_num_words-1:0]   waddr;

  assign waddr      = addr_q[l2_num_words+1:2];
  assign misaligned = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                      (i_req_size[1] && (i_req_addr[1:0] != 2'b00));

`ifdef SRAM_BRIDGE_MISALIGN_TRAP_EN
  logic err_q;
  assign mis_trap     = misaligned;
  assign addr_in      = i_req_addr;
  assign o_resp_error = err_q;
`else
  assign mis_trap     = 1'b0;
  assign o_resp_error = 1'b0;
  // Snap misaligned addresses down to the natural boundary of the access size.
  always_comb begin
    addr_in = i_req_addr;
    if (i_req_size == 2'b01) addr_in[0] = 1'b0;
    else if (i_req_size[1])  addr_in[1:0] = 2'b00;
  end
`endif

  // Enables and addresses decode from state only, so an async reset kills them at once.
  assign o_req_ready          = (state == IDLE);
  assign o_resp_valid         = (state == RESP);
  assign o_sram_read_enable   = (state == RD);
  assign o_sram_write_enable  = (state == WR);
  assign o_sram_addr_read     = (state == RD) ? waddr : '0;
  assign o_sram_addr_write    = (state == WR) ? waddr : '0;
  assign o_sram_data_to_write = (state == WR) ? wdata_q : '0;
  assign o_resp_rdata         = rdata_q;

  // Lane insert for sub-word stores and lane extract/extend for loads (little-endian).
  always_comb begin
    merged  = i_sram_data_read;
    shifted = i_sram_data_read >> {addr_q[1:0], 3'b000};
    loaded  = i_sram_data_read;
    case (size_q)
      2'b00: begin
        if (addr_q[1:0] == 2'd0) merged[7:0]   = wdata_q[7:0];
        if (addr_q[1:0] == 2'd1) merged[15:8]  = wdata_q[7:0];
        if (addr_q[1:0] == 2'd2) merged[23:16] = wdata_q[7:0];
        if (addr_q[1:0] == 2'd3) merged[31:24] = wdata_q[7:0];
        loaded = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
        loaded = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        merged = wdata_q;
        loaded = i_sram_data_read;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: word stores skip the read, sub-word stores go RD/DATA/WR.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_req_valid) begin
        if (mis_trap)                      state_nxt = RESP;
        else if (i_req_we && i_req_size[1]) state_nxt = WR;
        else                               state_nxt = RD;
      end
      RD:   state_nxt = DATA;
      DATA: state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: if (i_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, RMW merge and load response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_BRIDGE_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_req_valid) begin
          addr_q  <= addr_in;
          size_q  <= i_req_size;
          we_q    <= i_req_we;
          uns_q   <= i_req_unsigned;
          wdata_q <= i_req_wdata;
          rdata_q <= '0;
`ifdef SRAM_BRIDGE_MISALIGN_TRAP_EN
          err_q   <= mis_trap;
`endif
        end
        DATA: begin
          if (we_q) wdata_q <= merged;
          else      rdata_q <= loaded;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Directed bench for sram_lsu_bridge with a behavioural SRAM and a response scoreboard.
module tb_sram_lsu_bridge;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0, i_req_we = 1'b0, i_req_unsigned = 1'b0;
  logic [13:0] i_req_addr = '0;
  logic [1:0]  i_req_size = '0;
  logic [31:0] i_req_wdata = '0;
  logic        i_resp_ready = 1'b1;
  logic        o_req_ready, o_resp_valid, o_resp_error;
  logic [31:0] o_resp_rdata, i_sram_data_read, o_sram_data_to_write;
  logic        o_sram_read_enable, o_sram_write_enable;
  logic [11:0] o_sram_addr_read, o_sram_addr_write;

  logic [31:0] mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  int total = 0, bad = 0;

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  exp_t sbq[$];

  sram_lsu_bridge #(.num_words(4096), .l2_num_words(12)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_error(o_resp_error),
    .o_sram_read_enable(o_sram_read_enable), .o_sram_addr_read(o_sram_addr_read),
    .i_sram_data_read(i_sram_data_read), .o_sram_write_enable(o_sram_write_enable),
    .o_sram_addr_write(o_sram_addr_write), .o_sram_data_to_write(o_sram_data_to_write)
  );

  always #5 i_clk = ~i_clk;

  // SRAM model: registered read, synchronous write, plus a backdoor write port.
  always @(posedge i_clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (o_sram_write_enable) mem[o_sram_addr_write] <= o_sram_data_to_write;
    if (o_sram_read_enable) i_sram_data_read <= mem[o_sram_addr_read];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge i_clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge i_clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [13:0] a,
                     input logic [1:0] sz, input logic u, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, input int lat,
                     input int nre, input int nwe, input int stall);
    exp_t e, got;
    int cyc, rc, wc, both;
    cyc = 0; rc = 0; wc = 0; both = 0;
    @(negedge i_clk);
    chk({tag, "_req_ready"}, 128'(o_req_ready), 128'(1));
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_size = sz;
    i_req_unsigned = u; i_req_wdata = wd;
    i_resp_ready = (stall == 0);
    e.rdata = er; e.err = ee; e.lat = lat;
    sbq.push_back(e);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_wdata = '0;
    while (1) begin
      @(negedge i_clk);
      cyc++;
      rc += int'(o_sram_read_enable);
      wc += int'(o_sram_write_enable);
      if (o_sram_read_enable && o_sram_write_enable) both++;
      if (o_resp_valid || cyc >= 20) break;
    end
    got = sbq.pop_front();
    chk({tag, "_resp_valid"}, 128'(o_resp_valid), 128'(1));
    if (!o_resp_valid) return;
    chk({tag, "_rdata"},   128'(o_resp_rdata), 128'(got.rdata));
    chk({tag, "_error"},   128'(o_resp_error), 128'(got.err));
    chk({tag, "_latency"}, 128'(cyc), 128'(got.lat));
    chk({tag, "_n_reads"}, 128'(rc), 128'(nre));
    chk({tag, "_n_writes"}, 128'(wc), 128'(nwe));
    chk({tag, "_en_overlap"}, 128'(both), 128'(0));
    for (int i = 0; i < stall; i++) begin
      @(negedge i_clk);
      chk({tag, "_stall_hold"}, {o_resp_valid, o_req_ready, o_resp_error, o_resp_rdata},
          {1'b1, 1'b0, got.err, got.rdata});
    end
    i_resp_ready = 1'b1;
    @(negedge i_clk);
    chk({tag, "_back_idle"}, {o_req_ready, o_resp_valid}, {1'b1, 1'b0});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs",
        {o_req_ready, o_resp_valid, o_resp_rdata, o_resp_error, o_sram_read_enable,
         o_sram_addr_read, o_sram_write_enable, o_sram_addr_write, o_sram_data_to_write},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0});
    i_rst_n = 1'b1;

    txn("wstore", 1, 14'h010, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 0);
    chk("wstore_mem", 128'(mem[4]), 128'(32'hDEADBEEF));
    txn("wload", 0, 14'h010, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 0);
    txn("bstore", 1, 14'h012, 2'b00, 0, 32'h0000005A, 32'h0, 0, 4, 1, 1, 0);
    chk("bstore_mem", 128'(mem[4]), 128'(32'hDE5ABEEF));

    poke(12'd4, 32'h80112233);
    txn("lb_s_13",  0, 14'h013, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0, 0);
    txn("lhu_12",   0, 14'h012, 2'b01, 1, 32'h0, 32'h00008011, 0, 3, 1, 0, 0);
    txn("lh_s_12",  0, 14'h012, 2'b01, 0, 32'h0, 32'hFFFF8011, 0, 3, 1, 0, 0);
    txn("lbu_10",   0, 14'h010, 2'b00, 1, 32'h0, 32'h00000033, 0, 3, 1, 0, 0);
    txn("lb_s_11",  0, 14'h011, 2'b00, 0, 32'h0, 32'h00000022, 0, 3, 1, 0, 0);
`ifdef SRAM_BRIDGE_MISALIGN_TRAP_EN
    txn("lh_mis",   0, 14'h011, 2'b01, 0, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    txn("sw_mis",   1, 14'h016, 2'b10, 0, 32'h12345678, 32'h0, 1, 1, 0, 0, 0);
    chk("sw_mis_mem", 128'(mem[5]), 128'(32'h0));
`else
    txn("lh_mis",   0, 14'h011, 2'b01, 0, 32'h0, 32'h00002233, 0, 3, 1, 0, 0);
`endif

    poke(12'd5, 32'h11223344);
    txn("hstore",   1, 14'h016, 2'b01, 0, 32'h0000ABCD, 32'h0, 0, 4, 1, 1, 0);
    chk("hstore_mem", 128'(mem[5]), 128'(32'hABCD3344));
    txn("size11_ld", 0, 14'h014, 2'b11, 0, 32'h0, 32'hABCD3344, 0, 3, 1, 0, 0);
    txn("stall_ld",  0, 14'h010, 2'b10, 0, 32'h0, 32'h80112233, 0, 3, 1, 0, 5);

    // Reset during WR of a byte store: the write must never land.
    poke(12'd6, 32'hCAFEF00D);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 14'h018; i_req_size = 2'b00;
    i_req_unsigned = 1'b0; i_req_wdata = 32'h00000077;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_req_we = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_wr_en_before", 128'(o_sram_write_enable), 128'(1));
    i_rst_n = 1'b0;
    #1;
    chk("rst_wr_en_drop", 128'(o_sram_write_enable), 128'(0));
    @(posedge i_clk); #1;
    chk("rst_wr_mem", 128'(mem[6]), 128'(32'hCAFEF00D));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_wr_outputs",
        {o_req_ready, o_resp_valid, o_resp_rdata, o_resp_error, o_sram_read_enable,
         o_sram_addr_read, o_sram_write_enable, o_sram_addr_write, o_sram_data_to_write},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0});
    txn("post_rst_ld", 0, 14'h018, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 3, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
